// File: rtl/cache_policy_controller_pkg.sv
// cache_policy_controller_pkg: shared types for the cache policy controller
package cache_policy_controller_pkg;
  typedef enum logic [1:0] {LOAD, STORE, CLFLUSH} mem_op_e;
  typedef enum logic {WP_WRITEBACK, WP_WRITETHROUGH} write_policy_e;
  typedef enum logic [2:0] {ST_IDLE, ST_WRITEBACK, ST_ALLOCATE, ST_FLUSH, ST_WT_STORE} cache_ctrl_state_e;
  typedef struct packed {
    logic perform_write;
    logic set_selected_dirty_bit;
    logic clear_selected_dirty_bit;
    logic clear_selected_valid_bit;
    logic finish_new_line_install;
    logic set_hmem_block_address;
    logic use_victim_tag_for_hmem_block_address;
    logic process_lru_counters;
    logic miss_recovery_mode;
    logic count_hit;
    logic count_miss;
    logic count_read;
    logic count_write;
    logic count_writeback;
    logic hmem_single_word;
  } cache_strobes_t;
  function automatic bit is_pow2(int n);
    return n >= 2 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/cache_policy_controller_block_beat_counter.sv
// block_beat_counter: walks the word index of a multi-beat hmem burst
module block_beat_counter #(
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] index,
  output logic last
);
  localparam int IW = $clog2(WORDS_PER_BLOCK);
  assign last = advance && index == IW'(WORDS_PER_BLOCK - 1);
  // step one word per accepted beat; power-of-two size makes the wrap natural
  always_ff @(posedge clk)
    if (rst || clear) index <= '0;
    else if (advance) index <= index + 1'b1;
endmodule

// File: rtl/cache_policy_controller.sv
// cache_policy_controller: cache FSM with selectable write policy, allocation and beat counter
module cache_policy_controller
  import cache_policy_controller_pkg::*;
#(
  parameter int            WORDS_PER_BLOCK = 4,
  parameter write_policy_e WRITE_POLICY    = WP_WRITEBACK,
  parameter int            WRITE_ALLOCATE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  input  mem_op_e                            req_operation,
  output logic                               req_fulfilled,
  output logic                               hmem_req_valid,
  output mem_op_e                            hmem_req_operation,
  input  logic                               hmem_req_fulfilled,
  input  logic                               valid_block_match,
  input  logic                               valid_dirty_bit,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
  output cache_strobes_t                     strobes
);
  if (!is_pow2(WORDS_PER_BLOCK)) begin : g_bad_words
    $error("WORDS_PER_BLOCK must be a power of two >= 2");
  end
  cache_ctrl_state_e state, next;
  logic replay, last, idle, leave, hit_acc, store_op, alloc_done;
  assign idle       = state == ST_IDLE;
  assign leave      = idle && next != ST_IDLE;
  assign store_op   = req_operation == STORE;
  assign hit_acc    = idle && req_valid && valid_block_match && req_operation != CLFLUSH;
  assign alloc_done = last && state == ST_ALLOCATE;
  block_beat_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) u_beats (
    .clk(clk), .rst(reset), .clear(idle), .advance(hmem_req_fulfilled), .index(word_index), .last(last)
  );
  // state register and replay flag marking the re-evaluation after a line install
  always_ff @(posedge clk)
    if (reset) begin
      state  <= ST_IDLE;
      replay <= 1'b0;
    end else begin
      state  <= next;
      replay <= req_fulfilled ? 1'b0 : alloc_done ? 1'b1 : replay;
    end
  // next-state decision: request decode in IDLE, burst completion elsewhere
  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (req_valid) begin
        if (req_operation == CLFLUSH) next = valid_block_match && valid_dirty_bit ? ST_FLUSH : ST_IDLE;
        else if (valid_block_match) next = store_op && WRITE_POLICY == WP_WRITETHROUGH ? ST_WT_STORE : ST_IDLE;
        else if (store_op && WRITE_ALLOCATE == 0) next = ST_WT_STORE;
        else next = valid_dirty_bit ? ST_WRITEBACK : ST_ALLOCATE;
      end
      ST_WRITEBACK: next = last ? ST_ALLOCATE : state;
      ST_ALLOCATE, ST_FLUSH: next = last ? ST_IDLE : state;
      ST_WT_STORE: next = hmem_req_fulfilled ? ST_IDLE : state;
      default: next = cache_ctrl_state_e'('x);
    endcase
  end
  // datapath strobes, hmem request and requester completion
  always_comb begin
    strobes = '0;
    strobes.perform_write = state == ST_ALLOCATE || (hit_acc && store_op);
    strobes.set_selected_dirty_bit = hit_acc && store_op && WRITE_POLICY == WP_WRITEBACK;
    strobes.clear_selected_dirty_bit = last && (state == ST_WRITEBACK || state == ST_ALLOCATE || state == ST_FLUSH);
    strobes.clear_selected_valid_bit = (last && (state == ST_WRITEBACK || state == ST_FLUSH)) ||
      (idle && req_valid && req_operation == CLFLUSH && valid_block_match && !valid_dirty_bit);
    strobes.finish_new_line_install = alloc_done;
    strobes.set_hmem_block_address = leave || (last && state == ST_WRITEBACK);
    strobes.use_victim_tag_for_hmem_block_address = leave && (next == ST_WRITEBACK || next == ST_FLUSH);
    strobes.process_lru_counters = hit_acc || alloc_done;
    strobes.miss_recovery_mode = !idle || (leave && !valid_block_match);
    strobes.count_hit = hit_acc && !replay;
    strobes.count_miss = leave && !valid_block_match;
    strobes.count_read = hit_acc && req_operation == LOAD;
    strobes.count_write = (hit_acc && store_op) || (leave && !valid_block_match && next == ST_WT_STORE);
    strobes.count_writeback = leave && next == ST_WRITEBACK;
    strobes.hmem_single_word = state == ST_WT_STORE;
    req_fulfilled = (idle && req_valid && next == ST_IDLE) || (last && state == ST_FLUSH) ||
      (state == ST_WT_STORE && hmem_req_fulfilled);
    hmem_req_valid = !idle;
    hmem_req_operation = idle || state == ST_ALLOCATE ? LOAD : STORE;
    if (!(state inside {ST_IDLE, ST_WRITEBACK, ST_ALLOCATE, ST_FLUSH, ST_WT_STORE})) begin
      strobes = 'x;
      req_fulfilled = 1'bx;
      hmem_req_valid = 1'bx;
      hmem_req_operation = mem_op_e'('x);
    end
    if (reset) begin
      strobes = '0;
      req_fulfilled = 1'b0;
    end
  end
  a_req_held: assert property (@(posedge clk) disable iff (reset) state != ST_IDLE |-> req_valid);
endmodule

// File: tb/tb_cache_policy_controller.sv
// tb_cache_policy_controller: directed checks over write-back, write-through and no-allocate builds
module tb_cache_policy_controller;
  import cache_policy_controller_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic rv[3], hf[3], vbm[3], vdb[3], fu[3], hv[3];
  mem_op_e op[3], hop[3];
  cache_strobes_t st[3];
  logic [1:0] wi0, wi2;
  logic [2:0] wi1;
  int pass = 0, tot = 0;
  always #5 clk = ~clk;
  cache_policy_controller #(.WORDS_PER_BLOCK(4), .WRITE_POLICY(WP_WRITEBACK), .WRITE_ALLOCATE(1)) d0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_operation(op[0]), .req_fulfilled(fu[0]),
    .hmem_req_valid(hv[0]), .hmem_req_operation(hop[0]), .hmem_req_fulfilled(hf[0]),
    .valid_block_match(vbm[0]), .valid_dirty_bit(vdb[0]), .word_index(wi0), .strobes(st[0]));
  cache_policy_controller #(.WORDS_PER_BLOCK(8), .WRITE_POLICY(WP_WRITEBACK), .WRITE_ALLOCATE(1)) d1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_operation(op[1]), .req_fulfilled(fu[1]),
    .hmem_req_valid(hv[1]), .hmem_req_operation(hop[1]), .hmem_req_fulfilled(hf[1]),
    .valid_block_match(vbm[1]), .valid_dirty_bit(vdb[1]), .word_index(wi1), .strobes(st[1]));
  cache_policy_controller #(.WORDS_PER_BLOCK(4), .WRITE_POLICY(WP_WRITETHROUGH), .WRITE_ALLOCATE(0)) d2 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_operation(op[2]), .req_fulfilled(fu[2]),
    .hmem_req_valid(hv[2]), .hmem_req_operation(hop[2]), .hmem_req_fulfilled(hf[2]),
    .valid_block_match(vbm[2]), .valid_dirty_bit(vdb[2]), .word_index(wi2), .strobes(st[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rv[d] = 0; op[d] = LOAD; hf[d] = 0; vbm[d] = 0; vdb[d] = 0;
    end
    step(); step();
    for (int d = 0; d < 3; d++) begin
      tot++; if (hv[d] !== 1'b0) $display("FAIL reset_hmem_valid dut%0d got=%b exp=0", d, hv[d]); else pass++;
      tot++; if (hop[d] !== LOAD) $display("FAIL reset_hmem_op dut%0d got=%0d exp=%0d", d, hop[d], LOAD); else pass++;
      tot++; if (fu[d] !== 1'b0 || st[d] !== '0) $display("FAIL reset_strobes dut%0d got=%b/%h exp=0/0", d, fu[d], st[d]); else pass++;
    end
    reset = 0;
    step();
  endtask

  task automatic test_load_miss_wb4();
    rv[0] = 1; op[0] = LOAD; vbm[0] = 0; vdb[0] = 0; hf[0] = 0; #1;
    tot++; if (st[0].count_miss !== 1'b1 || st[0].miss_recovery_mode !== 1'b1 || st[0].set_hmem_block_address !== 1'b1)
      $display("FAIL lm_idle_strobes got=%h exp=miss,recovery,setaddr", st[0]); else pass++;
    tot++; if (fu[0] !== 1'b0) $display("FAIL lm_idle_fulfil got=%b exp=0", fu[0]); else pass++;
    step();
    for (int b = 0; b < 4; b++) begin
      hf[0] = 0; #1;
      tot++; if (wi0 !== 2'(b) || hv[0] !== 1'b1 || hop[0] !== LOAD || st[0].perform_write !== 1'b1)
        $display("FAIL lm_wait_beat%0d got=wi%0d v%b op%0d pw%b exp=wi%0d v1 op0 pw1", b, wi0, hv[0], hop[0], st[0].perform_write, b); else pass++;
      step();
      hf[0] = 1; #1;
      tot++; if (wi0 !== 2'(b) || st[0].finish_new_line_install !== (b == 3) || fu[0] !== 1'b0)
        $display("FAIL lm_beat%0d got=wi%0d fin%b fu%b exp=wi%0d fin%b fu0", b, wi0, st[0].finish_new_line_install, fu[0], b, b == 3); else pass++;
      step();
    end
    hf[0] = 0; vbm[0] = 1; #1;
    tot++; if (fu[0] !== 1'b1 || st[0].count_hit !== 1'b0 || st[0].count_read !== 1'b1 || hv[0] !== 1'b0)
      $display("FAIL lm_replay got=fu%b hit%b rd%b hv%b exp=fu1 hit0 rd1 hv0", fu[0], st[0].count_hit, st[0].count_read, hv[0]); else pass++;
    step();
    rv[0] = 0; step();
    rv[0] = 1; #1;
    tot++; if (fu[0] !== 1'b1 || st[0].count_hit !== 1'b1 || st[0].process_lru_counters !== 1'b1)
      $display("FAIL lm_fresh_hit got=fu%b hit%b lru%b exp=fu1 hit1 lru1", fu[0], st[0].count_hit, st[0].process_lru_counters); else pass++;
    step();
    rv[0] = 0; step();
  endtask

  task automatic test_store_miss_dirty_wb8();
    rv[1] = 1; op[1] = STORE; vbm[1] = 0; vdb[1] = 1; hf[1] = 1; #1;
    tot++; if (st[1].count_writeback !== 1'b1 || st[1].use_victim_tag_for_hmem_block_address !== 1'b1 || st[1].count_miss !== 1'b1)
      $display("FAIL smd_idle got=%h exp=wb,victim,miss", st[1]); else pass++;
    step();
    vdb[1] = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      tot++; if (hop[1] !== STORE || wi1 !== 3'(i) || fu[1] !== 1'b0 || st[1].clear_selected_valid_bit !== (i == 7))
        $display("FAIL smd_wb_beat%0d got=op%0d wi%0d fu%b cv%b exp=op1 wi%0d fu0 cv%b", i, hop[1], wi1, fu[1], st[1].clear_selected_valid_bit, i, i == 7); else pass++;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      tot++; if (hop[1] !== LOAD || wi1 !== 3'(i) || fu[1] !== 1'b0 || st[1].finish_new_line_install !== (i == 7))
        $display("FAIL smd_al_beat%0d got=op%0d wi%0d fu%b fin%b exp=op0 wi%0d fu0 fin%b", i, hop[1], wi1, fu[1], st[1].finish_new_line_install, i, i == 7); else pass++;
      step();
    end
    hf[1] = 0; vbm[1] = 1; #1;
    tot++; if (fu[1] !== 1'b1 || st[1].set_selected_dirty_bit !== 1'b1 || st[1].perform_write !== 1'b1 || st[1].count_hit !== 1'b0)
      $display("FAIL smd_replay got=fu%b sd%b pw%b hit%b exp=fu1 sd1 pw1 hit0", fu[1], st[1].set_selected_dirty_bit, st[1].perform_write, st[1].count_hit); else pass++;
    step();
    rv[1] = 0; step();
  endtask

  task automatic test_wt_store_hit();
    rv[2] = 1; op[2] = STORE; vbm[2] = 1; vdb[2] = 0; hf[2] = 0; #1;
    tot++; if (st[2].perform_write !== 1'b1 || st[2].set_selected_dirty_bit !== 1'b0 || st[2].count_hit !== 1'b1 || st[2].count_write !== 1'b1 || fu[2] !== 1'b0)
      $display("FAIL wt_idle got=%h fu%b exp=pw1 sd0 hit1 wr1 fu0", st[2], fu[2]); else pass++;
    step();
    #1;
    tot++; if (hv[2] !== 1'b1 || hop[2] !== STORE || st[2].hmem_single_word !== 1'b1 || fu[2] !== 1'b0)
      $display("FAIL wt_wait got=v%b op%0d sw%b fu%b exp=v1 op1 sw1 fu0", hv[2], hop[2], st[2].hmem_single_word, fu[2]); else pass++;
    step();
    hf[2] = 1; #1;
    tot++; if (fu[2] !== 1'b1) $display("FAIL wt_fulfil got=%b exp=1", fu[2]); else pass++;
    step();
    rv[2] = 0; hf[2] = 0; #1;
    tot++; if (hv[2] !== 1'b0) $display("FAIL wt_back_idle got=%b exp=0", hv[2]); else pass++;
    step();
  endtask

  task automatic test_no_allocate();
    rv[2] = 1; op[2] = STORE; vbm[2] = 0; vdb[2] = 1; hf[2] = 0; #1;
    tot++; if (st[2].count_miss !== 1'b1 || st[2].count_writeback !== 1'b0 || st[2].miss_recovery_mode !== 1'b1)
      $display("FAIL nwa_idle got=miss%b wb%b rec%b exp=1 0 1", st[2].count_miss, st[2].count_writeback, st[2].miss_recovery_mode); else pass++;
    step();
    hf[2] = 1; #1;
    tot++; if (fu[2] !== 1'b1 || st[2].finish_new_line_install !== 1'b0 || st[2].process_lru_counters !== 1'b0 || st[2].hmem_single_word !== 1'b1 || hop[2] !== STORE)
      $display("FAIL nwa_store got=fu%b fin%b lru%b sw%b op%0d exp=1 0 0 1 1", fu[2], st[2].finish_new_line_install, st[2].process_lru_counters, st[2].hmem_single_word, hop[2]); else pass++;
    step();
    rv[2] = 0; hf[2] = 0; step();
  endtask

  task automatic test_clflush();
    rv[0] = 1; op[0] = CLFLUSH; vbm[0] = 1; vdb[0] = 1; hf[0] = 0; #1;
    tot++; if (fu[0] !== 1'b0 || st[0].use_victim_tag_for_hmem_block_address !== 1'b1 || st[0].miss_recovery_mode !== 1'b0)
      $display("FAIL fl_idle got=fu%b vt%b rec%b exp=0 1 0", fu[0], st[0].use_victim_tag_for_hmem_block_address, st[0].miss_recovery_mode); else pass++;
    step();
    hf[0] = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tot++; if (hop[0] !== STORE || fu[0] !== (i == 3) || st[0].clear_selected_valid_bit !== (i == 3) || st[0].clear_selected_dirty_bit !== (i == 3))
        $display("FAIL fl_beat%0d got=op%0d fu%b cv%b cd%b exp=op1 all=%b", i, hop[0], fu[0], st[0].clear_selected_valid_bit, st[0].clear_selected_dirty_bit, i == 3); else pass++;
      step();
    end
    rv[0] = 0; hf[0] = 0; step();
    rv[0] = 1; vbm[0] = 0; vdb[0] = 1; #1;
    tot++; if (fu[0] !== 1'b1 || hv[0] !== 1'b0 || st[0].clear_selected_valid_bit !== 1'b0)
      $display("FAIL fl_miss got=fu%b hv%b cv%b exp=1 0 0", fu[0], hv[0], st[0].clear_selected_valid_bit); else pass++;
    step();
    vbm[0] = 1; vdb[0] = 0; #1;
    tot++; if (fu[0] !== 1'b1 || st[0].clear_selected_valid_bit !== 1'b1)
      $display("FAIL fl_clean_hit got=fu%b cv%b exp=1 1", fu[0], st[0].clear_selected_valid_bit); else pass++;
    step();
    rv[0] = 0; step();
  endtask

  task automatic test_reset_mid_allocate();
    rv[0] = 1; op[0] = LOAD; vbm[0] = 0; vdb[0] = 0; hf[0] = 1; step();
    step(); step();
    tot++; if (wi0 !== 2'd2 || hv[0] !== 1'b1) $display("FAIL rst_pre got=wi%0d hv%b exp=wi2 hv1", wi0, hv[0]); else pass++;
    reset = 1; rv[0] = 0; #1;
    tot++; if (fu[0] !== 1'b0 || st[0] !== '0) $display("FAIL rst_during got=fu%b st%h exp=0 0", fu[0], st[0]); else pass++;
    step();
    reset = 0; hf[0] = 0; #1;
    tot++; if (hv[0] !== 1'b0 || wi0 !== 2'd0 || fu[0] !== 1'b0) $display("FAIL rst_after got=hv%b wi%0d fu%b exp=0 0 0", hv[0], wi0, fu[0]); else pass++;
    step();
    rv[0] = 1; #1;
    tot++; if (st[0].count_miss !== 1'b1 || fu[0] !== 1'b0 || st[0].count_hit !== 1'b0)
      $display("FAIL rst_cold_miss got=miss%b fu%b hit%b exp=1 0 0", st[0].count_miss, fu[0], st[0].count_hit); else pass++;
    step();
    hf[0] = 1;
    for (int i = 0; i < 4; i++) step();
    hf[0] = 0; vbm[0] = 1; #1;
    tot++; if (fu[0] !== 1'b1 || st[0].count_hit !== 1'b0) $display("FAIL rst_cold_replay got=fu%b hit%b exp=1 0", fu[0], st[0].count_hit); else pass++;
    step();
    rv[0] = 0; step();
  endtask

  initial begin
    test_reset();
    test_load_miss_wb4();
    test_store_miss_dirty_wb8();
    test_wt_store_hit();
    test_no_allocate();
    test_clflush();
    test_reset_mid_allocate();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout after %0d checks", tot);
    $fatal(1);
  end
endmodule
